// File: rtl/ring_buffer.sv
// rtl/ring_buffer.sv - FWFT FIFO of arbitrary depth with wrapping pointers and sticky overflow/underflow flags
// Buffers captured print-mechanism samples between the capture front end and host read-out.

module incrementer #(
  parameter int MAX_VALUE = 99,
  parameter int INCREMENT = 1,
  parameter int WIDTH     = 7
) (
  input  logic [WIDTH-1:0] value_i,
  output logic [WIDTH-1:0] value_o
);
  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0] INC_C = WIDTH'(INCREMENT);

  // Wrap past MAX_VALUE back around to 0 rather than to the next power of two.
  always_comb begin
    if (value_i > MAX_C - INC_C) begin
      value_o = value_i + INC_C - MAX_C - WIDTH'(1);
    end else begin
      value_o = value_i + INC_C;
    end
  end
endmodule

module ring_buffer #(
  parameter int DEPTH = 100,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       write_en,
  input  logic [WIDTH-1:0]           write_data,
  input  logic                       read_en,
  output logic [WIDTH-1:0]           read_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] write_ptr_q, write_ptr_d, write_ptr_inc;
  logic [PW-1:0] read_ptr_q, read_ptr_d, read_ptr_inc;
  logic [CW-1:0] count_q, count_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          flush;
  logic          wr_accept;
  logic          rd_accept;

  incrementer #(.MAX_VALUE(DEPTH - 1), .INCREMENT(1), .WIDTH(PW)) u_wr_inc (
    .value_i (write_ptr_q),
    .value_o (write_ptr_inc)
  );

  incrementer #(.MAX_VALUE(DEPTH - 1), .INCREMENT(1), .WIDTH(PW)) u_rd_inc (
    .value_i (read_ptr_q),
    .value_o (read_ptr_inc)
  );

  assign flush     = rst || clear;
  assign wr_accept = write_en && !full_q && !flush;
  assign rd_accept = read_en && !empty_q && !flush;

  always_comb begin
    write_ptr_d = write_ptr_q;
    read_ptr_d  = read_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q || (write_en && full_q);
    underflow_d = underflow_q || (read_en && empty_q);
    if (wr_accept) write_ptr_d = write_ptr_inc;
    if (rd_accept) read_ptr_d = read_ptr_inc;
    if (wr_accept && !rd_accept) count_d = count_q + CW'(1);
    if (rd_accept && !wr_accept) count_d = count_q - CW'(1);
    if (flush) begin
      write_ptr_d = '0;
      read_ptr_d  = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == DEPTH_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      write_ptr_q <= '0;
      read_ptr_q  <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      write_ptr_q <= write_ptr_d;
      read_ptr_q  <= read_ptr_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) mem[write_ptr_q] <= write_data;
  end

  assign read_data = empty_q ? '0 : mem[read_ptr_q];
  assign empty     = empty_q;
  assign full      = full_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
endmodule

// File: tb/tb_ring_buffer.sv
// tb/tb_ring_buffer.sv - directed self-checking bench for ring_buffer at DEPTH=5, WIDTH=8

module tb_ring_buffer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       write_en = 1'b0;
  logic [7:0] write_data = '0;
  logic       read_en = 1'b0;
  logic [7:0] read_data;
  logic       empty, full, overflow, underflow;
  logic [2:0] count;

  int errors = 0;
  int checks = 0;

  ring_buffer #(.DEPTH(5), .WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .write_en   (write_en),
    .write_data (write_data),
    .read_en    (read_en),
    .read_data  (read_data),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] fill_a [5];
    fill_a = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    // Reset
    tick(); tick();
    rst = 1'b0;
    check("rst_empty", 16'(empty), 16'd1);
    check("rst_full", 16'(full), 16'd0);
    check("rst_count", 16'(count), 16'd0);
    check("rst_rdata", 16'(read_data), 16'h00);
    check("rst_ovf", 16'(overflow), 16'd0);
    check("rst_unf", 16'(underflow), 16'd0);

    // Fill
    for (int i = 0; i < 5; i++) begin
      write_en = 1'b1; write_data = fill_a[i];
      tick();
      if (i == 0) check("first_word_latency", 16'(read_data), 16'h11);
    end
    write_en = 1'b0;
    check("fill_full", 16'(full), 16'd1);
    check("fill_count", 16'(count), 16'd5);

    // Read 3
    for (int i = 0; i < 3; i++) begin
      check("drain1_data", 16'(read_data), 16'(fill_a[i]));
      read_en = 1'b1;
      tick();
    end
    read_en = 1'b0;
    check("drain1_count", 16'(count), 16'd2);
    check("drain1_full", 16'(full), 16'd0);

    // Wrap writes
    write_en = 1'b1; write_data = 8'h66; tick();
    write_data = 8'h77; tick();
    write_en = 1'b0;
    check("wrap_count", 16'(count), 16'd4);

    check("wrap_d0", 16'(read_data), 16'h44); read_en = 1'b1; tick();
    check("wrap_d1", 16'(read_data), 16'h55); tick();
    check("wrap_d2", 16'(read_data), 16'h66); tick();
    check("wrap_d3", 16'(read_data), 16'h77); tick();
    read_en = 1'b0;
    check("wrap_empty", 16'(empty), 16'd1);
    check("wrap_count0", 16'(count), 16'd0);
    check("wrap_rdata0", 16'(read_data), 16'h00);

    // Overflow
    for (int i = 1; i <= 5; i++) begin
      write_en = 1'b1; write_data = 8'(i); tick();
    end
    write_data = 8'h99; tick();
    write_en = 1'b0;
    check("ovf_count", 16'(count), 16'd5);
    check("ovf_flag", 16'(overflow), 16'd1);
    check("ovf_full", 16'(full), 16'd1);
    write_en = 1'b1; read_en = 1'b1; write_data = 8'h99; tick();
    write_en = 1'b0; read_en = 1'b0;
    check("ovf_rw_count", 16'(count), 16'd4);
    check("ovf_rw_full", 16'(full), 16'd0);
    for (int i = 2; i <= 5; i++) begin
      check("ovf_drain", 16'(read_data), 16'(i));
      read_en = 1'b1; tick();
    end
    read_en = 1'b0;
    check("ovf_drain_empty", 16'(empty), 16'd1);

    // Underflow
    read_en = 1'b1; tick();
    read_en = 1'b0;
    check("unf_flag", 16'(underflow), 16'd1);
    check("unf_count", 16'(count), 16'd0);
    write_en = 1'b1; read_en = 1'b1; write_data = 8'hA5; tick();
    write_en = 1'b0; read_en = 1'b0;
    check("unf_rw_data", 16'(read_data), 16'hA5);
    check("unf_rw_count", 16'(count), 16'd1);
    check("unf_sticky", 16'(underflow), 16'd1);
    check("ovf_sticky", 16'(overflow), 16'd1);

    // Clear, then steady streaming at count=2
    clear = 1'b1; tick();
    clear = 1'b0;
    check("clr_flags", 16'({overflow, underflow}), 16'd0);
    check("clr_empty", 16'(empty), 16'd1);
    write_en = 1'b1; write_data = 8'd0; tick();
    write_data = 8'd1; tick();
    for (int i = 0; i < 20; i++) begin
      check("stream_data", 16'(read_data), 16'(i));
      write_data = 8'(i + 2); read_en = 1'b1;
      tick();
      check("stream_count", 16'(count), 16'd2);
    end
    write_en = 1'b0; read_en = 1'b0;
    check("stream_tail", 16'(read_data), 16'd20);
    check("stream_flags", 16'({overflow, underflow}), 16'd0);

    // Build count=3 with overflow set, then clear with a simultaneous write
    write_en = 1'b1;
    write_data = 8'd22; tick();
    write_data = 8'd23; tick();
    write_data = 8'd24; tick();
    write_data = 8'h99; tick();
    write_en = 1'b0;
    read_en = 1'b1; tick(); tick();
    read_en = 1'b0;
    check("pre_clr_count", 16'(count), 16'd3);
    check("pre_clr_ovf", 16'(overflow), 16'd1);
    clear = 1'b1; write_en = 1'b1; write_data = 8'hEE; tick();
    clear = 1'b0; write_en = 1'b0;
    check("clr_mid_empty", 16'(empty), 16'd1);
    check("clr_mid_count", 16'(count), 16'd0);
    check("clr_mid_ovf", 16'(overflow), 16'd0);
    check("clr_mid_rdata", 16'(read_data), 16'h00);
    write_en = 1'b1; write_data = 8'h5A; tick();
    write_en = 1'b0;
    check("post_clr_data", 16'(read_data), 16'h5A);
    check("post_clr_count", 16'(count), 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
